// File: rtl/sraml_arbiter_2to1.sv
// sraml_arbiter_2to1: shares one sram-like port between inst and data masters, one transaction outstanding.
// Define SRAML_ARB_RR_EN for round-robin grant on simultaneous requests; default is fixed priority (data over inst).
module sraml_arbiter_2to1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_nxt;
    logic   owner, owner_nxt, win, sel, sel_req, any_req, grant, addr_ok, data_ok;
`ifdef SRAML_ARB_RR_EN
    logic   last, last_nxt;
    assign win = (inst_req && data_req) ? ~last : data_req;
`else
    assign win = data_req;
`endif
    // owner bit: 0 = inst, 1 = data
    assign any_req = inst_req | data_req;
    assign grant   = state == IDLE && any_req;
    assign sel     = state == IDLE ? win : owner;
    assign sel_req = sel ? data_req : inst_req;
    assign addr_ok = !rst && bus_addr_ok && (grant || state == ADDR);
    assign data_ok = !rst && bus_data_ok && (state == DATA || addr_ok);
    assign bus_req   = !rst && state != DATA && sel_req;
    assign bus_wr    = sel ? data_wr    : inst_wr;
    assign bus_size  = sel ? data_size  : inst_size;
    assign bus_addr  = sel ? data_addr  : inst_addr;
    assign bus_wdata = sel ? data_wdata : inst_wdata;
    assign inst_addr_ok = addr_ok && !sel;
    assign inst_data_ok = data_ok && !sel;
    assign data_addr_ok = addr_ok && sel;
    assign data_data_ok = data_ok && sel;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;
    always_comb begin
        state_nxt = data_ok ? IDLE : addr_ok ? DATA : grant ? ADDR : state;
        owner_nxt = grant ? win : owner;
    end
`ifdef SRAML_ARB_RR_EN
    assign last_nxt = data_ok ? sel : last;
    always_ff @(posedge clk) begin
        if (rst) last <= 1'b0;
        else     last <= last_nxt;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end
endmodule

// File: tb/tb_sraml_arbiter_2to1.sv
// tb_sraml_arbiter_2to1: directed plan steps plus random traffic, checked against a transaction-level model.
module tb_sraml_arbiter_2to1;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, bus_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata, data_addr, data_wdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    int          checks = 0, errors = 0;
    // model: a transaction waiting for its address / data handshake, its master, the master served last
    bit          wait_addr, wait_data, m_own, m_last;

    always #5 clk = ~clk;

    sraml_arbiter_2to1 dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit pick();
        if (wait_addr || wait_data) return m_own;
`ifdef SRAML_ARB_RR_EN
        if (inst_req && data_req) return !m_last;
`endif
        return data_req;
    endfunction

    task automatic cyc();
        bit idle, any, s, aok, dok;
        #1;
        idle = !(wait_addr || wait_data);
        any  = inst_req || data_req;
        s    = pick();
        aok  = !rst && bus_addr_ok && (wait_addr || (idle && any));
        dok  = !rst && bus_data_ok && (wait_data || aok);
        chk("bus_req", bus_req, !rst && (idle ? any : wait_addr && (s ? data_req : inst_req)));
        chk("bus_wr", bus_wr, s ? data_wr : inst_wr);
        chk("bus_size", bus_size, s ? data_size : inst_size);
        chk("bus_addr", bus_addr, s ? data_addr : inst_addr);
        chk("bus_wdata", bus_wdata, s ? data_wdata : inst_wdata);
        chk("inst_addr_ok", inst_addr_ok, aok && !s);
        chk("inst_data_ok", inst_data_ok, dok && !s);
        chk("data_addr_ok", data_addr_ok, aok && s);
        chk("data_data_ok", data_data_ok, dok && s);
        chk("inst_rdata", inst_rdata, bus_rdata);
        chk("data_rdata", data_rdata, bus_rdata);
        @(posedge clk);
        if (rst) begin
            wait_addr = 0; wait_data = 0; m_own = 0; m_last = 0;
        end else if (dok) begin
            wait_addr = 0; wait_data = 0; m_last = s;
        end else if (aok) begin
            wait_addr = 0; wait_data = 1; m_own = s;
        end else if (idle && any) begin
            wait_addr = 1; m_own = s;
        end
        #1;
    endtask

    task automatic quiet();
        inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    endtask

    initial begin
        rst = 1; quiet();
        inst_wr = 0; inst_size = 2'b10; inst_addr = 0; inst_wdata = 0;
        data_wr = 0; data_size = 2'b10; data_addr = 0; data_wdata = 0; bus_rdata = 0;
        wait_addr = 0; wait_data = 0; m_own = 0; m_last = 0;
        cyc(); cyc();
        rst = 0;
        #1; chk("reset bus_req", bus_req, 0); chk("reset inst_addr_ok", inst_addr_ok, 0);
        chk("reset data_data_ok", data_data_ok, 0);
        cyc();
        // inst-only read
        inst_req = 1; inst_addr = 32'hBFC00000; bus_addr_ok = 1;
        #1; chk("ird bus_addr", bus_addr, 32'hBFC00000); chk("ird inst_addr_ok", inst_addr_ok, 1);
        chk("ird data_addr_ok", data_addr_ok, 0);
        cyc();
        inst_req = 0; bus_addr_ok = 0;
        #1; chk("ird data-phase bus_req", bus_req, 0);
        cyc();
        bus_data_ok = 1; bus_rdata = 32'h3C1D8000;
        #1; chk("ird inst_data_ok", inst_data_ok, 1); chk("ird inst_rdata", inst_rdata, 32'h3C1D8000);
        chk("ird data_data_ok", data_data_ok, 0);
        cyc();
        quiet();
        // simultaneous requests
        inst_req = 1; data_req = 1; inst_addr = 32'h1FC00010; data_addr = 32'h80001000; data_wr = 1;
        bus_addr_ok = 1;
        #1; chk("sim bus_addr", bus_addr, 32'h80001000); chk("sim bus_wr", bus_wr, 1);
        chk("sim data_addr_ok", data_addr_ok, 1); chk("sim inst_addr_ok", inst_addr_ok, 0);
        cyc();
        bus_addr_ok = 0; bus_data_ok = 1;
        #1; chk("sim data_data_ok", data_data_ok, 1); chk("sim inst_data_ok", inst_data_ok, 0);
        cyc();
        // repeat double request; also a same-cycle completion
        bus_addr_ok = 1; bus_data_ok = 1;
`ifdef SRAML_ARB_RR_EN
        #1; chk("rep bus_addr", bus_addr, 32'h1FC00010); chk("rep inst_data_ok", inst_data_ok, 1);
        chk("rep inst_addr_ok", inst_addr_ok, 1);
        cyc();
        #1; chk("alt bus_addr", bus_addr, 32'h80001000); chk("alt bus_req", bus_req, 1);
        cyc();
        #1; chk("alt2 bus_addr", bus_addr, 32'h1FC00010);
`else
        #1; chk("rep bus_addr", bus_addr, 32'h80001000); chk("rep data_data_ok", data_data_ok, 1);
        chk("rep data_addr_ok", data_addr_ok, 1);
        cyc();
        #1; chk("next bus_req", bus_req, 1); chk("next bus_addr", bus_addr, 32'h80001000);
`endif
        cyc();
        quiet(); data_wr = 0;
        // delayed addr_ok
        data_req = 1; data_addr = 32'h80002000;
        for (int i = 0; i < 4; i++) begin
            #1; chk("dly bus_req", bus_req, 1); chk("dly bus_addr", bus_addr, 32'h80002000);
            chk("dly data_addr_ok", data_addr_ok, 0);
            cyc();
        end
        bus_addr_ok = 1;
        #1; chk("dly data_addr_ok", data_addr_ok, 1);
        cyc();
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        #1; chk("dly data_data_ok", data_data_ok, 1);
        cyc();
        quiet();
        // preemption attempt while inst waits for data
        inst_req = 1; bus_addr_ok = 1;
        cyc();
        inst_req = 0; data_req = 1; bus_addr_ok = 0;
        for (int i = 0; i < 2; i++) begin
            #1; chk("pre bus_req", bus_req, 0); chk("pre data_addr_ok", data_addr_ok, 0);
            cyc();
        end
        bus_data_ok = 1;
        #1; chk("pre inst_data_ok", inst_data_ok, 1); chk("pre bus_req", bus_req, 0);
        cyc();
        bus_data_ok = 0;
        #1; chk("pre grant bus_req", bus_req, 1); chk("pre grant bus_addr", bus_addr, 32'h80002000);
        cyc();
        // reset while waiting for addr_ok
        rst = 1; quiet();
        #1; chk("rst bus_req", bus_req, 0);
        cyc();
        rst = 0; bus_data_ok = 1;
        #1; chk("post-rst bus_req", bus_req, 0); chk("stray inst_data_ok", inst_data_ok, 0);
        chk("stray data_data_ok", data_data_ok, 0);
        cyc();
        quiet();
        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            inst_req = $urandom_range(0, 1); data_req = $urandom_range(0, 1);
            if (wait_addr && !rst) begin
                if (m_own) data_req = 1; else inst_req = 1;
            end
            inst_wr = $urandom_range(0, 1); data_wr = $urandom_range(0, 1);
            inst_size = 2'($urandom_range(0, 2)); data_size = 2'($urandom_range(0, 2));
            inst_addr = $urandom; data_addr = $urandom; inst_wdata = $urandom; data_wdata = $urandom;
            bus_rdata = $urandom;
            bus_addr_ok = ($urandom_range(0, 2) == 0); bus_data_ok = ($urandom_range(0, 2) == 0);
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
